store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-write buffer between the MEM stage and Data_Memory, whose single Mem_Addr port is shared by reads and writes.
//  Queues 64-bit doubleword stores in a small FIFO and drains them one per cycle whenever no load needs the port.
//  Loads have priority. A load exactly matching a buffered store is forwarded from the buffer.
//  A load that partially overlaps a buffered store stalls until that store has drained.
// PARAMETERS
//  DEPTH   4   store entries; power of 2, >=2
//  ADDR_W  64  byte-address width
//  DATA_W  64  data width (doubleword)
// PORTS
//  clk             in   1       clock, all state on posedge
//  reset           in   1       synchronous, active-high
//  st_valid        in   1       store request from MEM stage
//  st_addr         in   ADDR_W  store byte address
//  st_data         in   DATA_W  store data
//  st_ready        out  1       store accepted this cycle when st_valid&&st_ready
//  ld_valid        in   1       load request from MEM stage
//  ld_addr         in   ADDR_W  load byte address
//  ld_data         out  DATA_W  load result (combinational)
//  ld_stall        out  1       load cannot complete this cycle; hold request
//  mem_addr        out  ADDR_W  to Data_Memory Mem_Addr
//  mem_write_data  out  DATA_W  to Data_Memory Write_Data
//  mem_write       out  1       to Data_Memory MemWrite
//  mem_read        out  1       to Data_Memory MemRead
//  mem_read_data   in   DATA_W  from Data_Memory Read_Data
//  sb_count        out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//  sb_empty        out  1       sb_count==0 (used for fence/halt)
// BEHAVIOUR
//  - Reset: head=tail=count=0; all entries invalid.
//    While reset=1: st_ready=0, mem_write=0, mem_read=0, ld_stall=0, ld_data=0.
//    After reset: st_ready=1, sb_empty=1. Reset mid-operation discards all entries; none are written.
//  - Storage: circular FIFO of {addr,data}. Pointers wrap mod DEPTH. Age order runs head (oldest) to tail-1 (youngest).
//  - Push: when st_valid&&st_ready, write at tail on posedge.
//    st_ready = (count!=DEPTH). It stays 0 when full even if a pop occurs in the same cycle.
//  - Load lookup (combinational, valid entries only):
//    - exact: entry.addr==ld_addr
//    - overlap: entry.addr!=ld_addr and either (entry.addr-ld_addr) or (ld_addr-entry.addr), mod 2^ADDR_W, is <8.
//  - Load result, evaluated in priority order:
//    1. Any overlap: ld_stall=1, mem_read=0, ld_data=0.
//    2. Else any exact match: ld_data = data of youngest matching entry; mem_read=0, ld_stall=0.
//    3. Else: mem_read=1, mem_addr=ld_addr, ld_data=mem_read_data, ld_stall=0.
//    4. ld_valid=0: ld_stall=0, mem_read=0, ld_data=0.
//  - Drain:
//    - mem_write = (count!=0) && !mem_read. When asserted, mem_addr/mem_write_data = head entry, and the entry is popped on that posedge.
//    - Drain also proceeds while a load is stalled or forwarded, so stalls cannot deadlock.
//    - Simultaneous push and pop: count unchanged, both pointers advance.
//  - A store accepted in cycle N is not visible to a load until cycle N+1. The pipeline guarantees ordering.
//  - Latency: load 0 cycles (combinational). Store-to-memory is at least 1 cycle after acceptance.
//  - No arithmetic on data. Address compares use full ADDR_W; there are no alignment checks.
// TESTING
//  1. Reset, store 0x10<-0xAA, ld_valid=0: next cycle sb_count=1, mem_write=1, mem_addr=0x10, data 0xAA; following cycle sb_count=0, sb_empty=1.
//  2. Two stores pending, hold ld_valid addr 0x0 (no match) 3 cycles: mem_read=1, ld_data=0x4, mem_write=0, sb_count=2; drop ld_valid -> drains in 2 cycles.
//  3. Stores 0x8<-0x11 then 0x8<-0x22, load 0x8 held: ld_data=0x22, mem_read=0, ld_stall=0; buffer drains 0x11 then 0x22 during the load.
//  4. Store 0x10<-0x5 buffered, load 0x14: ld_stall=1, mem_write=1 that cycle; next cycle ld_stall=0, mem_read=1, mem_addr=0x14.
//  5. Hold load at 0x30 (no match), issue 5 stores: 4 accepted, st_ready=0 on the 5th, sb_count=4; release load -> pop, st_ready=1 the next cycle, 5th accepted.
//  6. Three entries buffered, pulse reset 1 cycle: no mem_write for those entries, sb_count=0, st_ready=1 after reset.

Source files
------------

// File: rtl/store_buffer_if.sv
// ============================================================================
//  Module      : store_buffer_if
//  Description : Bus bundle between the MEM stage, the store buffer and Data_Memory.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_stall;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;
    logic [CNT_W-1:0]  sb_count;
    logic              sb_empty;

    // The master is the surrounding pipeline plus Data_Memory's read port.
    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        input  st_ready, ld_data, ld_stall, mem_addr, mem_write_data,
               mem_write, mem_read, sb_count, sb_empty
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        output st_ready, ld_data, ld_stall, mem_addr, mem_write_data,
               mem_write, mem_read, sb_count, sb_empty
    );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// ============================================================================
//  Module      : store_buffer
//  Description : Posted-write FIFO with load forwarding and partial-overlap stall.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  wire logic     clk,
    input  wire logic     reset,
    store_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] C_DW_BYTES = ADDR_W'(8);
    localparam logic [CNT_W-1:0]  C_FULL     = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] entry_addr_q [DEPTH];
    logic [ADDR_W-1:0] entry_addr_d [DEPTH];
    logic [DATA_W-1:0] entry_data_q [DEPTH];
    logic [DATA_W-1:0] entry_data_d [DEPTH];

    logic [PTR_W-1:0]  w_age_idx [DEPTH];
    logic [ADDR_W-1:0] w_dist_up [DEPTH];
    logic [ADDR_W-1:0] w_dist_dn [DEPTH];
    logic              w_any_overlap, w_any_exact;
    logic [DATA_W-1:0] w_fwd_data;
    logic              w_st_ready, w_mem_read, w_mem_write, w_push;

    // Walk entries oldest to youngest so the last exact hit is the youngest.
    always_comb begin
        w_any_overlap = 1'b0;
        w_any_exact   = 1'b0;
        w_fwd_data    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_age_idx[k] = head_q + PTR_W'(k);
            w_dist_up[k] = entry_addr_q[w_age_idx[k]] - bus.ld_addr;
            w_dist_dn[k] = bus.ld_addr - entry_addr_q[w_age_idx[k]];
            if (CNT_W'(k) < count_q) begin
                if (w_dist_up[k] == '0) begin
                    w_any_exact = 1'b1;
                    w_fwd_data  = entry_data_q[w_age_idx[k]];
                end else if ((w_dist_up[k] < C_DW_BYTES) || (w_dist_dn[k] < C_DW_BYTES)) begin
                    w_any_overlap = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_st_ready         = 1'b0;
        w_mem_read         = 1'b0;
        w_mem_write        = 1'b0;
        bus.ld_stall       = 1'b0;
        bus.ld_data        = '0;
        bus.mem_addr       = entry_addr_q[head_q];
        bus.mem_write_data = entry_data_q[head_q];
        if (!reset) begin
            w_st_ready = (count_q != C_FULL);
            if (bus.ld_valid) begin
                if (w_any_overlap) begin
                    bus.ld_stall = 1'b1;
                end else if (w_any_exact) begin
                    bus.ld_data = w_fwd_data;
                end else begin
                    w_mem_read  = 1'b1;
                    bus.ld_data = bus.mem_read_data;
                end
            end
            // Stalled and forwarded loads leave the port free, so draining continues.
            w_mem_write = (count_q != '0) && !w_mem_read;
            if (w_mem_read) begin
                bus.mem_addr = bus.ld_addr;
            end
        end
    end

    assign bus.st_ready  = w_st_ready;
    assign bus.mem_read  = w_mem_read;
    assign bus.mem_write = w_mem_write;
    assign bus.sb_count  = count_q;
    assign bus.sb_empty  = (count_q == '0);
    assign w_push        = bus.st_valid && w_st_ready;

    always_comb begin
        head_d       = head_q + PTR_W'(w_mem_write);
        tail_d       = tail_q + PTR_W'(w_push);
        count_d      = count_q + CNT_W'(w_push) - CNT_W'(w_mem_write);
        entry_addr_d = entry_addr_q;
        entry_data_d = entry_data_q;
        if (w_push) begin
            entry_addr_d[tail_q] = bus.st_addr;
            entry_data_d[tail_q] = bus.st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: validity is implied by head/count.
    always_ff @(posedge clk) begin
        entry_addr_q <= entry_addr_d;
        entry_data_q <= entry_data_d;
    end
endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Directed and randomized self-checking bench for store_buffer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) sb_if ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sb_if)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic        e_st_ready, e_ld_stall, e_mem_read, e_mem_write;
    logic [63:0] e_ld_data, e_mem_addr, e_mem_wdata;

    // Reference: a queue of pending stores, oldest at the front.
    function automatic void model_eval();
        logic        ovl, hit;
        logic [63:0] hd, dist_a, dist_b;
        ovl = 1'b0; hit = 1'b0; hd = '0;
        e_st_ready = 1'b0; e_ld_stall = 1'b0; e_mem_read = 1'b0; e_mem_write = 1'b0;
        e_ld_data = '0; e_mem_addr = '0; e_mem_wdata = '0;
        if (reset) return;
        e_st_ready = (q.size() < DEPTH);
        if (sb_if.ld_valid) begin
            foreach (q[i]) begin
                dist_a = q[i].a - sb_if.ld_addr;
                dist_b = sb_if.ld_addr - q[i].a;
                if (q[i].a == sb_if.ld_addr) begin
                    hit = 1'b1;
                    hd  = q[i].d;
                end else if (dist_a < 64'd8 || dist_b < 64'd8) begin
                    ovl = 1'b1;
                end
            end
            if (ovl) e_ld_stall = 1'b1;
            else if (hit) e_ld_data = hd;
            else begin
                e_mem_read = 1'b1;
                e_mem_addr = sb_if.ld_addr;
                e_ld_data  = sb_if.mem_read_data;
            end
        end
        e_mem_write = (q.size() != 0) && !e_mem_read;
        if (e_mem_write) begin
            e_mem_addr  = q[0].a;
            e_mem_wdata = q[0].d;
        end
    endfunction

    function automatic void model_update();
        if (reset) q.delete();
        else begin
            if (e_mem_write) void'(q.pop_front());
            if (sb_if.st_valid && e_st_ready) q.push_back('{a: sb_if.st_addr, d: sb_if.st_data});
        end
    endfunction

    task automatic adv();
        model_eval();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d);
        sb_if.st_valid = 1'b1; sb_if.st_addr = a; sb_if.st_data = d;
        adv();
        sb_if.st_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sb_if.st_valid = 1'b1; sb_if.st_addr = 64'h10; sb_if.st_data = 64'h1;
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h20; sb_if.mem_read_data = 64'hDEAD;
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.st_ready !== 1'b0) begin n_errors++; $display("FAIL rst_st_ready: got %b want 0", sb_if.st_ready); end
        n_checks++; if (sb_if.mem_write !== 1'b0) begin n_errors++; $display("FAIL rst_mem_write: got %b want 0", sb_if.mem_write); end
        n_checks++; if (sb_if.mem_read !== 1'b0) begin n_errors++; $display("FAIL rst_mem_read: got %b want 0", sb_if.mem_read); end
        n_checks++; if (sb_if.ld_stall !== 1'b0) begin n_errors++; $display("FAIL rst_ld_stall: got %b want 0", sb_if.ld_stall); end
        n_checks++; if (sb_if.ld_data !== 64'h0) begin n_errors++; $display("FAIL rst_ld_data: got %h want 0", sb_if.ld_data); end
        adv();
        reset = 1'b0; sb_if.st_valid = 1'b0; sb_if.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sb_if.st_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_st_ready: got %b want 1", sb_if.st_ready); end
        n_checks++; if (sb_if.sb_empty !== 1'b1 || sb_if.sb_count !== 3'd0) begin n_errors++; $display("FAIL post_rst_empty: got empty=%b count=%0d want 1/0", sb_if.sb_empty, sb_if.sb_count); end
        adv();
    endtask

    task automatic test_single_drain();
        push(64'h10, 64'hAA);
        @(negedge clk);
        n_checks++; if (sb_if.sb_count !== 3'd1) begin n_errors++; $display("FAIL drain_count: got %0d want 1", sb_if.sb_count); end
        n_checks++; if (sb_if.mem_write !== 1'b1 || sb_if.mem_addr !== 64'h10 || sb_if.mem_write_data !== 64'hAA) begin
            n_errors++; $display("FAIL drain_write: got we=%b a=%h d=%h want 1/10/aa", sb_if.mem_write, sb_if.mem_addr, sb_if.mem_write_data); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.sb_count !== 3'd0 || sb_if.sb_empty !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got count=%0d empty=%b want 0/1", sb_if.sb_count, sb_if.sb_empty); end
        adv();
    endtask

    task automatic test_load_priority();
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h0; sb_if.mem_read_data = 64'h4;
        push(64'h100, 64'h1);
        push(64'h200, 64'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (sb_if.mem_read !== 1'b1 || sb_if.ld_data !== 64'h4 || sb_if.mem_write !== 1'b0 || sb_if.sb_count !== 3'd2) begin
                n_errors++; $display("FAIL prio_load: got rd=%b data=%h we=%b count=%0d want 1/4/0/2", sb_if.mem_read, sb_if.ld_data, sb_if.mem_write, sb_if.sb_count); end
            adv();
        end
        sb_if.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sb_if.mem_write !== 1'b1 || sb_if.mem_addr !== 64'h100) begin n_errors++; $display("FAIL prio_drain0: got we=%b a=%h want 1/100", sb_if.mem_write, sb_if.mem_addr); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.mem_write !== 1'b1 || sb_if.mem_addr !== 64'h200) begin n_errors++; $display("FAIL prio_drain1: got we=%b a=%h want 1/200", sb_if.mem_write, sb_if.mem_addr); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.sb_empty !== 1'b1) begin n_errors++; $display("FAIL prio_empty: got %b want 1", sb_if.sb_empty); end
    endtask

    task automatic test_forward();
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h40; sb_if.mem_read_data = 64'h77;
        push(64'h8, 64'h11);
        push(64'h8, 64'h22);
        sb_if.ld_addr = 64'h8;
        @(negedge clk);
        n_checks++; if (sb_if.ld_data !== 64'h22 || sb_if.mem_read !== 1'b0 || sb_if.ld_stall !== 1'b0) begin
            n_errors++; $display("FAIL fwd_young: got data=%h rd=%b stall=%b want 22/0/0", sb_if.ld_data, sb_if.mem_read, sb_if.ld_stall); end
        n_checks++; if (sb_if.mem_write !== 1'b1 || sb_if.mem_write_data !== 64'h11) begin n_errors++; $display("FAIL fwd_drain0: got we=%b d=%h want 1/11", sb_if.mem_write, sb_if.mem_write_data); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.ld_data !== 64'h22 || sb_if.mem_write_data !== 64'h22 || sb_if.mem_write !== 1'b1) begin
            n_errors++; $display("FAIL fwd_drain1: got data=%h we=%b d=%h want 22/1/22", sb_if.ld_data, sb_if.mem_write, sb_if.mem_write_data); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.mem_read !== 1'b1 || sb_if.ld_data !== 64'h77 || sb_if.sb_count !== 3'd0) begin
            n_errors++; $display("FAIL fwd_after: got rd=%b data=%h count=%0d want 1/77/0", sb_if.mem_read, sb_if.ld_data, sb_if.sb_count); end
        adv();
        sb_if.ld_valid = 1'b0;
    endtask

    task automatic test_overlap();
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h40; sb_if.mem_read_data = 64'h5A;
        push(64'h10, 64'h5);
        sb_if.ld_addr = 64'h18;
        @(negedge clk);
        n_checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.mem_read !== 1'b1 || sb_if.sb_count !== 3'd1) begin
            n_errors++; $display("FAIL ovl_dist8: got stall=%b rd=%b count=%0d want 0/1/1", sb_if.ld_stall, sb_if.mem_read, sb_if.sb_count); end
        adv();
        sb_if.ld_addr = 64'h14;
        @(negedge clk);
        n_checks++; if (sb_if.ld_stall !== 1'b1 || sb_if.mem_read !== 1'b0 || sb_if.ld_data !== 64'h0 || sb_if.mem_write !== 1'b1) begin
            n_errors++; $display("FAIL ovl_stall: got stall=%b rd=%b data=%h we=%b want 1/0/0/1", sb_if.ld_stall, sb_if.mem_read, sb_if.ld_data, sb_if.mem_write); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.mem_read !== 1'b1 || sb_if.mem_addr !== 64'h14) begin
            n_errors++; $display("FAIL ovl_release: got stall=%b rd=%b a=%h want 0/1/14", sb_if.ld_stall, sb_if.mem_read, sb_if.mem_addr); end
        adv();
        sb_if.ld_addr = 64'h40;
        push(64'h0, 64'h9);
        sb_if.ld_addr = 64'hFFFF_FFFF_FFFF_FFF9;
        @(negedge clk);
        n_checks++; if (sb_if.ld_stall !== 1'b1) begin n_errors++; $display("FAIL ovl_wrap: got stall=%b want 1", sb_if.ld_stall); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.ld_stall !== 1'b0 || sb_if.mem_read !== 1'b1) begin n_errors++; $display("FAIL ovl_wrap_rel: got stall=%b rd=%b want 0/1", sb_if.ld_stall, sb_if.mem_read); end
        adv();
        sb_if.ld_valid = 1'b0;
    endtask

    task automatic test_full();
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h30; sb_if.st_valid = 1'b1; sb_if.st_data = 64'h3;
        for (int i = 0; i < DEPTH; i++) begin
            sb_if.st_addr = 64'h100 + 64'(i * 8);
            @(negedge clk);
            n_checks++; if (sb_if.st_ready !== 1'b1) begin n_errors++; $display("FAIL full_accept%0d: got %b want 1", i, sb_if.st_ready); end
            adv();
        end
        sb_if.st_addr = 64'h200;
        @(negedge clk);
        n_checks++; if (sb_if.st_ready !== 1'b0 || sb_if.sb_count !== 3'd4) begin n_errors++; $display("FAIL full_block: got rdy=%b count=%0d want 0/4", sb_if.st_ready, sb_if.sb_count); end
        adv();
        sb_if.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sb_if.st_ready !== 1'b0 || sb_if.mem_write !== 1'b1 || sb_if.mem_addr !== 64'h100) begin
            n_errors++; $display("FAIL full_pop: got rdy=%b we=%b a=%h want 0/1/100", sb_if.st_ready, sb_if.mem_write, sb_if.mem_addr); end
        adv();
        @(negedge clk);
        n_checks++; if (sb_if.st_ready !== 1'b1 || sb_if.sb_count !== 3'd3) begin n_errors++; $display("FAIL full_reopen: got rdy=%b count=%0d want 1/3", sb_if.st_ready, sb_if.sb_count); end
        adv();
        sb_if.st_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sb_if.sb_count !== 3'd3) begin n_errors++; $display("FAIL full_pushpop: got %0d want 3", sb_if.sb_count); end
        adv(); adv();
        @(negedge clk);
        n_checks++; if (sb_if.mem_addr !== 64'h200 || sb_if.mem_write !== 1'b1) begin n_errors++; $display("FAIL full_fifth: got we=%b a=%h want 1/200", sb_if.mem_write, sb_if.mem_addr); end
        adv();
    endtask

    task automatic test_reset_mid();
        sb_if.ld_valid = 1'b1; sb_if.ld_addr = 64'h30;
        push(64'h300, 64'h1); push(64'h308, 64'h2); push(64'h310, 64'h3);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (sb_if.mem_write !== 1'b0 || sb_if.sb_count !== 3'd3) begin n_errors++; $display("FAIL rmid_in: got we=%b count=%0d want 0/3", sb_if.mem_write, sb_if.sb_count); end
        adv();
        reset = 1'b0; sb_if.ld_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (sb_if.sb_count !== 3'd0 || sb_if.mem_write !== 1'b0 || sb_if.st_ready !== 1'b1) begin
            n_errors++; $display("FAIL rmid_after: got count=%0d we=%b rdy=%b want 0/0/1", sb_if.sb_count, sb_if.mem_write, sb_if.st_ready); end
        adv();
    endtask

    function automatic logic [63:0] pick_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 19) return 64'hFFFF_FFFF_FFFF_FFFC;
        if (r >= 12) return 64'(r * 8 + 4);
        return 64'(r * 8);
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset                = ($urandom_range(0, 59) == 0);
            sb_if.st_valid       = $urandom_range(0, 1) == 1;
            sb_if.st_addr        = pick_addr();
            sb_if.st_data        = {$urandom, $urandom};
            sb_if.ld_valid       = $urandom_range(0, 2) == 0;
            sb_if.ld_addr        = pick_addr();
            sb_if.mem_read_data  = {$urandom, $urandom};
            @(negedge clk);
            model_eval();
            n_checks++; if (sb_if.st_ready !== e_st_ready) begin n_errors++; $display("FAIL rnd_st_ready@%0d: got %b want %b", n, sb_if.st_ready, e_st_ready); end
            n_checks++; if (sb_if.ld_stall !== e_ld_stall) begin n_errors++; $display("FAIL rnd_ld_stall@%0d: got %b want %b", n, sb_if.ld_stall, e_ld_stall); end
            n_checks++; if (sb_if.mem_read !== e_mem_read) begin n_errors++; $display("FAIL rnd_mem_read@%0d: got %b want %b", n, sb_if.mem_read, e_mem_read); end
            n_checks++; if (sb_if.mem_write !== e_mem_write) begin n_errors++; $display("FAIL rnd_mem_write@%0d: got %b want %b", n, sb_if.mem_write, e_mem_write); end
            n_checks++; if (sb_if.ld_data !== e_ld_data) begin n_errors++; $display("FAIL rnd_ld_data@%0d: got %h want %h", n, sb_if.ld_data, e_ld_data); end
            n_checks++; if (sb_if.sb_count !== 3'(q.size()) || sb_if.sb_empty !== (q.size() == 0)) begin
                n_errors++; $display("FAIL rnd_count@%0d: got %0d/%b want %0d", n, sb_if.sb_count, sb_if.sb_empty, q.size()); end
            if (e_mem_read || e_mem_write) begin
                n_checks++; if (sb_if.mem_addr !== e_mem_addr) begin n_errors++; $display("FAIL rnd_mem_addr@%0d: got %h want %h", n, sb_if.mem_addr, e_mem_addr); end
            end
            if (e_mem_write) begin
                n_checks++; if (sb_if.mem_write_data !== e_mem_wdata) begin n_errors++; $display("FAIL rnd_wdata@%0d: got %h want %h", n, sb_if.mem_write_data, e_mem_wdata); end
            end
            adv();
        end
        reset = 1'b0; sb_if.st_valid = 1'b0; sb_if.ld_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        sb_if.st_valid = 1'b0; sb_if.st_addr = '0; sb_if.st_data = '0;
        sb_if.ld_valid = 1'b0; sb_if.ld_addr = '0; sb_if.mem_read_data = '0;
        #1;
        test_reset();
        test_single_drain();
        test_load_priority();
        test_forward();
        test_overlap();
        test_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
